control_part4: RTL and testbench

Sequencing controller for the part-4 matrix-vector engine (datapath_part4). It accepts a streamed 8x8 weight matrix W and an 8-element vector X over a valid/ready input handshake. It drives the datapath's write enables, addresses and accumulator controls to compute y[r] = sum_k W[r][k]·X[k] for r = 0..7, and presents each y[r] (output_data from the datapath) with a valid/ready output handshake.

---
 rtl/part4_pkg.sv | 19 +
 rtl/control_part4.sv | 165 ++++++++++++++++
 tb/tb_control_part4.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/part4_pkg.sv
// Shared types and sizing for the part-4 matrix-vector engine.
package part4_pkg;

  localparam int DIM     = 8;
  localparam int DATA_W  = 14;
  localparam int ACC_W   = 28;
  localparam int IDX_W   = $clog2(DIM);
  localparam int WADDR_W = 2 * IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_X,
    MAC,
    DRAIN,
    OUT
  } state_t;

endpackage

// File: rtl/control_part4.sv
// Sequencing controller for the part-4 matrix-vector engine: loads W and X
// over a valid/ready stream, steps the datapath through eight MAC rows and
// hands each y[r] out over a valid/ready handshake.
module control_part4
  import part4_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               reload_w,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [IDX_W-1:0]   addr_x,
  output logic               wr_en_x,
  output logic [WADDR_W-1:0] addr_w,
  output logic               wr_en_w,
  output logic               clear_acc,
  output logic               en_acc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   row_idx,
  output logic               busy,
  output logic               done
);

  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DIM - 1);
  localparam logic [WADDR_W-1:0] LAST_W   = WADDR_W'(DIM * DIM - 1);

  state_t               state_q, state_d;
  logic [WADDR_W-1:0]   w_cnt_q, w_cnt_d;
  logic [IDX_W-1:0]     x_cnt_q, x_cnt_d;
  logic [IDX_W-1:0]     row_q, row_d;
  logic [IDX_W-1:0]     k_q, k_d;
  logic                 en_acc_q, en_acc_d;

  // State and counter registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      w_cnt_q  <= '0;
      x_cnt_q  <= '0;
      row_q    <= '0;
      k_q      <= '0;
      en_acc_q <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      state_q  <= state_d;
      w_cnt_q  <= w_cnt_d;
      x_cnt_q  <= x_cnt_d;
      row_q    <= row_d;
      k_q      <= k_d;
      en_acc_q <= en_acc_d;
    end
  end

  // Next-state and counter updates; counters wrap, transitions fire on terminal count.
  always_comb begin
    // NOTE: every target gets a default first, so no path leaves a value
    // unassigned and no latch is inferred.
    state_d  = state_q;
    w_cnt_d  = w_cnt_q;
    x_cnt_d  = x_cnt_q;
    row_d    = row_q;
    k_d      = k_q;
    // en_acc trails MAC by one cycle to line up with the memory read latency.
    en_acc_d = (state_q == MAC);

    unique case (state_q)
      IDLE: begin
        w_cnt_d = '0;
        x_cnt_d = '0;
        row_d   = '0;
        k_d     = '0;
        if (start) begin
          state_d = reload_w ? LOAD_W : LOAD_X;
        end
      end
      LOAD_W: begin
        if (in_valid) begin
          w_cnt_d = w_cnt_q + 1'b1;
          if (w_cnt_q == LAST_W) begin
            state_d = LOAD_X;
          end
        end
      end
      LOAD_X: begin
        if (in_valid) begin
          x_cnt_d = x_cnt_q + 1'b1;
          if (x_cnt_q == LAST_IDX) begin
            state_d = MAC;
            row_d   = '0;
            k_d     = '0;
          end
        end
      end
      MAC: begin
        k_d = k_q + 1'b1;
        if (k_q == LAST_IDX) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          k_d = '0;
          if (row_q == LAST_IDX) begin
            row_d   = '0;
            state_d = IDLE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = MAC;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath controls and handshake outputs; everything idles at zero outside its owning state.
  always_comb begin
    in_ready  = 1'b0;
    addr_x    = '0;
    wr_en_x   = 1'b0;
    addr_w    = '0;
    wr_en_w   = 1'b0;
    clear_acc = 1'b0;
    out_valid = 1'b0;
    row_idx   = '0;
    done      = 1'b0;

    unique case (state_q)
      LOAD_W: begin
        in_ready = 1'b1;
        addr_w   = w_cnt_q;
        wr_en_w  = in_valid;
      end
      LOAD_X: begin
        in_ready = 1'b1;
        addr_x   = x_cnt_q;
        wr_en_x  = in_valid;
      end
      MAC: begin
        addr_x    = k_q;
        addr_w    = {row_q, k_q};
        clear_acc = (k_q == '0);
      end
      OUT: begin
        out_valid = 1'b1;
        row_idx   = row_q;
        done      = out_ready && (row_q == LAST_IDX);
      end
      default: begin
      end
    endcase
  end

  assign en_acc = en_acc_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_control_part4.sv
// Self-checking bench for control_part4: a directed vector table, a job-level
// reference model driven by random handshakes, and reset/timing corner cases.
module tb_control_part4;

  typedef struct packed {
    logic       in_ready;
    logic [2:0] addr_x;
    logic       wr_en_x;
    logic [5:0] addr_w;
    logic       wr_en_w;
    logic       clear_acc;
    logic       en_acc;
    logic       out_valid;
    logic [2:0] row_idx;
    logic       busy;
    logic       done;
  } outs_t;

  typedef struct {
    logic  start;
    logic  reload_w;
    logic  in_valid;
    logic  out_ready;
    outs_t exp_o;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, reload_w, in_valid, out_ready;
  logic       in_ready, wr_en_x, wr_en_w, clear_acc, en_acc, out_valid, busy, done;
  logic [2:0] addr_x, row_idx;
  logic [5:0] addr_w;

  int checks = 0;
  int errors = 0;

  // Reference model: job phase (0 idle, 1 loading, 2 computing) plus counts.
  int m_mode, m_n, m_row, m_t;
  bit m_reload;

  // Per-job pulse counters gathered from the DUT.
  int n_w, n_x, n_done;

  always #5 clk = ~clk;

  control_part4 dut (
    .clk       (clk),
    .rst       (rst_n),
    .start     (start),
    .reload_w  (reload_w),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .addr_x    (addr_x),
    .wr_en_x   (wr_en_x),
    .addr_w    (addr_w),
    .wr_en_w   (wr_en_w),
    .clear_acc (clear_acc),
    .en_acc    (en_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .row_idx   (row_idx),
    .busy      (busy),
    .done      (done)
  );

  function automatic outs_t sample();
    outs_t o;
    o.in_ready  = in_ready;
    o.addr_x    = addr_x;
    o.wr_en_x   = wr_en_x;
    o.addr_w    = addr_w;
    o.wr_en_w   = wr_en_w;
    o.clear_acc = clear_acc;
    o.en_acc    = en_acc;
    o.out_valid = out_valid;
    o.row_idx   = row_idx;
    o.busy      = busy;
    o.done      = done;
    return o;
  endfunction

  function automatic outs_t mk(logic ir, int ax, logic wx, int aw, logic ww,
                               logic clr, logic en, logic ov, int row,
                               logic bsy, logic dn);
    outs_t o;
    o.in_ready  = ir;
    o.addr_x    = 3'(ax);
    o.wr_en_x   = wx;
    o.addr_w    = 6'(aw);
    o.wr_en_w   = ww;
    o.clear_acc = clr;
    o.en_acc    = en;
    o.out_valid = ov;
    o.row_idx   = 3'(row);
    o.busy      = bsy;
    o.done      = dn;
    return o;
  endfunction

  task automatic check_o(input string name, input outs_t act, input outs_t exp_o);
    checks++;
    if (act !== exp_o) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_o);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_n = 0; m_row = 0; m_t = 0; m_reload = 1'b0;
  endfunction

  // Expected outputs derived from where the job stands, not from RTL states.
  function automatic outs_t model_out(logic iv, logic ordy);
    outs_t o = '0;
    if (m_mode == 1) begin
      o.busy     = 1'b1;
      o.in_ready = 1'b1;
      if (m_reload && m_n < 64) begin
        o.addr_w  = 6'(m_n);
        o.wr_en_w = iv;
      end else begin
        o.addr_x  = 3'(m_n - (m_reload ? 64 : 0));
        o.wr_en_x = iv;
      end
    end else if (m_mode == 2) begin
      o.busy   = 1'b1;
      o.en_acc = (m_t >= 1 && m_t <= 8);
      if (m_t < 8) begin
        o.addr_x    = 3'(m_t);
        o.addr_w    = 6'(m_row * 8 + m_t);
        o.clear_acc = (m_t == 0);
      end else if (m_t >= 9) begin
        o.out_valid = 1'b1;
        o.row_idx   = 3'(m_row);
        o.done      = ordy && (m_row == 7);
      end
    end
    return o;
  endfunction

  function automatic void model_adv(logic s, logic rl, logic iv, logic ordy);
    case (m_mode)
      0: if (s) begin m_mode = 1; m_n = 0; m_reload = rl; end
      1: if (iv) begin
           m_n++;
           if (m_n == (m_reload ? 72 : 8)) begin m_mode = 2; m_row = 0; m_t = 0; end
         end
      default: begin
        if (m_t >= 9 && ordy) begin
          if (m_row == 7) m_mode = 0;
          else begin m_row++; m_t = 0; end
        end else begin
          m_t++;
        end
      end
    endcase
  endfunction

  // One clock cycle: drive on the falling edge, compare 1 ns later, advance model.
  task automatic step(input logic s, input logic rl, input logic iv, input logic ordy);
    outs_t act, exp_o;
    @(negedge clk);
    start = s; reload_w = rl; in_valid = iv; out_ready = ordy;
    #1;
    act   = sample();
    exp_o = model_out(iv, ordy);
    check_o("cycle", act, exp_o);
    if (act.wr_en_w) n_w++;
    if (act.wr_en_x) n_x++;
    if (act.done)    n_done++;
    model_adv(s, rl, iv, ordy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0; reload_w = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check_o("reset_outputs", sample(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Runs one job from start; exp_cycles>0 checks start-to-done latency,
  // abort_row>=0 returns early at MAC k=3 of that row.
  task automatic run_job(input logic rl, input int p_iv, input int p_or,
                         input bit stall3, input int abort_row, input int exp_cycles);
    int cyc;
    int budget;
    logic s, rl2, iv, ordy;
    n_w = 0; n_x = 0; n_done = 0;
    step(1'b1, rl, 1'($urandom_range(1)), 1'($urandom_range(1)));
    cyc = 1;
    budget = 0;
    while (m_mode != 0 && budget < 4000) begin
      if (abort_row >= 0 && m_mode == 2 && m_row == abort_row && m_t == 3) return;
      iv   = ($urandom_range(99) < p_iv);
      ordy = ($urandom_range(99) < p_or);
      if (stall3 && m_mode == 2 && m_row == 3 && m_t >= 9 && m_t < 14) ordy = 1'b0;
      s    = ($urandom_range(3) == 0);
      rl2  = 1'($urandom_range(1));
      step(s, rl2, iv, ordy);
      cyc++;
      budget++;
    end
    check_int("job_finished", int'(budget < 4000), 1);
    check_int("wr_en_w_pulses", n_w, rl ? 64 : 0);
    check_int("wr_en_x_pulses", n_x, 8);
    check_int("done_pulses", n_done, 1);
    if (exp_cycles > 0) check_int("start_to_done_cycles", cyc, exp_cycles);
  endtask

  vec_t vecs[22];

  initial begin
    // Directed table: reload_w=0 job through X load, first row of MAC, OUT, row 1 entry.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,0)};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1,0,1,0,0,0,0,0,0,1,0)};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, mk(1,1,0,0,0,0,0,0,0,1,0)};
    for (int i = 1; i < 8; i++)
      vecs[2 + i] = '{1'b0, 1'b0, 1'b1, 1'b0, mk(1,i,1,0,0,0,0,0,0,1,0)};
    for (int k = 0; k < 8; k++)
      vecs[10 + k] = '{(k == 2), 1'b1, 1'b0, 1'b0,
                       mk(0,k,0,k,0,(k == 0),(k >= 1),0,0,1,0)};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,0,1,0,0,1,0)};
    vecs[19] = '{1'b1, 1'b1, 1'b1, 1'b0, mk(0,0,0,0,0,0,0,1,0,1,0)};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,1,0,1,0)};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, mk(0,0,0,8,0,1,0,0,0,1,0)};

    rst_n = 1'b0;
    start = 1'b0; reload_w = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_o("reset_state", sample(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      start = vecs[i].start; reload_w = vecs[i].reload_w;
      in_valid = vecs[i].in_valid; out_ready = vecs[i].out_ready;
      #1;
      check_o($sformatf("vec%0d", i), sample(), vecs[i].exp_o);
    end

    do_reset();

    // Full reload job with no stalls, then a reuse-W job with no stalls.
    run_job(1'b1, 100, 100, 1'b0, -1, 153);
    run_job(1'b0, 100, 100, 1'b0, -1, 89);
    // Randomised handshakes, with start noise throughout.
    run_job(1'b1, 60, 50, 1'b0, -1, 0);
    run_job(1'b0, 50, 70, 1'b1, -1, 0);
    run_job(1'b1, 40, 100, 1'b1, -1, 0);

    // Asynchronous reset during MAC of row 2.
    run_job(1'b1, 70, 100, 1'b0, 2, 0);
    @(posedge clk);
    #1;
    check_int("busy_before_abort", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_o("async_reset_outputs", sample(), '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_job(1'b1, 80, 80, 1'b1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
